// File: rtl/prio_rr_arbiter_if.sv
// Request/grant bundle between requesters and prio_rr_arbiter.
// The requester side drives mode and req; the arbiter drives the grant outputs.
interface prio_rr_arbiter_if #(
   parameter int N = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic          mode;
   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_id;

   modport master (
      output mode, req,
      input  grant, grant_valid, grant_id
   );

   modport slave (
      input  mode, req,
      output grant, grant_valid, grant_id
   );
endinterface

// File: rtl/prio_rr_arbiter.sv
// N-way non-preemptive arbiter with a run-time choice of fixed or round-robin
// priority. Grants are registered, with a hold limit and no hand-over bubble.
module prio_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              resetn,
   prio_rr_arbiter_if.slave  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HSAT = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
   localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;

   logic [N-1:0]  others;
   logic [N-1:0]  cand;
   logic [IW-1:0] win_id;
   logic          found;
   logic          take;

   // While busy the owner is never a candidate; on release its bit is already 0.
   always_comb begin
      others = bus.req & ~(N'(1) << id_q);
      cand   = (state_q == BUSY) ? others : bus.req;
   end

   always_comb begin
      win_id = '0;
      found  = 1'b0;
      if (bus.mode) begin
         for (int k = 1; k <= N; k++) begin
            if (!found && cand[(int'(last_q) + k) % N]) begin
               found  = 1'b1;
               win_id = IW'((int'(last_q) + k) % N);
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) win_id = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      last_d  = last_q;
      hold_d  = hold_q;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) take = 1'b1;
         end
         BUSY: begin
            if (!bus.req[id_q]) begin
               if (|bus.req) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
                  hold_d  = '0;
               end
            end else if (MAX_HOLD != 0 && hold_q == HMAX && |others) begin
               take = 1'b1;
            end else if (hold_q < HSAT) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         state_d = BUSY;
         grant_d = N'(1) << win_id;
         id_d    = win_id;
         last_d  = win_id;
         hold_d  = HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         id_q    <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.grant_id    = id_q;
endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (N=4, MAX_HOLD=4).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_prio_rr_arbiter;
   logic clk = 1'b0;
   logic resetn;
   int   n_chk = 0;
   int   n_fail = 0;

   prio_rr_arbiter_if #(.N(4)) bus ();

   prio_rr_arbiter #(
      .N(4),
      .MAX_HOLD(4)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input string tag, input logic [3:0] g,
                               input logic [1:0] id);
      check({tag, ".grant"}, 32'(bus.grant), 32'(g));
      check({tag, ".valid"}, 32'(bus.grant_valid), 32'(|g));
      check({tag, ".id"}, 32'(bus.grant_id), 32'(id));
   endtask

   initial begin
      resetn   = 1'b0;
      bus.mode = 1'b0;
      bus.req  = 4'b1111;
      step();
      step();
      expect_grant("reset", 4'b0000, 2'd0);
      resetn = 1'b1;
      step();
      expect_grant("post_reset", 4'b0001, 2'd0);

      // fixed priority
      bus.req = 4'b1100;
      step();
      expect_grant("fp_1100", 4'b0100, 2'd2);
      bus.req = 4'b1101;
      step();
      expect_grant("fp_nopreempt", 4'b0100, 2'd2);
      bus.req = 4'b1001;
      step();
      expect_grant("fp_handover", 4'b0001, 2'd0);

      // round-robin rotation
      bus.mode = 1'b1;
      bus.req  = 4'b1110;
      step();
      expect_grant("rr_1", 4'b0010, 2'd1);
      bus.req = 4'b1101;
      step();
      expect_grant("rr_2", 4'b0100, 2'd2);
      bus.req = 4'b1011;
      step();
      expect_grant("rr_3", 4'b1000, 2'd3);
      bus.req = 4'b0111;
      step();
      expect_grant("rr_wrap", 4'b0001, 2'd0);

      // hold limit, starting from a fresh pointer
      resetn  = 1'b0;
      bus.req = 4'b0000;
      step();
      expect_grant("hl_reset", 4'b0000, 2'd0);
      resetn  = 1'b1;
      bus.req = 4'b0011;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i >= 4 && i < 8)
            expect_grant($sformatf("hl_c%0d", i), 4'b0010, 2'd1);
         else
            expect_grant($sformatf("hl_c%0d", i), 4'b0001, 2'd0);
      end
      bus.req = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("hl_solo%0d", i), 32'(bus.grant), 32'h1);
      end

      // mode switch mid-grant
      bus.req = 4'b0100;
      step();
      expect_grant("ms_own2", 4'b0100, 2'd2);
      bus.req  = 4'b0111;
      bus.mode = 1'b0;
      step();
      expect_grant("ms_keep1", 4'b0100, 2'd2);
      step();
      expect_grant("ms_keep2", 4'b0100, 2'd2);
      bus.req = 4'b0011;
      step();
      expect_grant("ms_release", 4'b0001, 2'd0);

      // reset mid-operation
      bus.req = 4'b1000;
      step();
      expect_grant("rm_own3", 4'b1000, 2'd3);
      resetn = 1'b0;
      step();
      expect_grant("rm_reset", 4'b0000, 2'd0);
      resetn   = 1'b1;
      bus.mode = 1'b1;
      bus.req  = 4'b1010;
      step();
      expect_grant("rm_rr", 4'b0010, 2'd1);

      // release with nothing pending returns to idle
      bus.req = 4'b0000;
      step();
      expect_grant("idle", 4'b0000, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Parametrised N-way bus arbiter that grants one requester at a time, with a run-time choice between fixed-priority and round-robin arbitration. Grants are non-preemptive, but an optional hold limit forces hand-over when other requesters are waiting. Grants are registered, and hand-over between requesters costs no idle cycle. It is the next-generation arbiter for shared-resource access in the design, replacing fixed 3-way priority arbitration.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles while another request is pending. 0 disables the limit.
- clk  input  1  clock, rising edge.
- resetn  input  1  reset; synchronous, active-low.
- mode  input  1  arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
- req  input  N  request vector, level-sensitive; bit i belongs to requester i.
- grant  output  N  one-hot grant, registered; all zero when idle.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  max(1,$clog2(N))  index of the granted requester; 0 when idle.

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: one owner index is granted.
- Reset (resetn=0 at a clk edge):
  - state=IDLE, grant=0, grant_valid=0, grant_id=0.
  - hold counter=0.
  - round-robin pointer last=N-1, so index 0 is searched first.
- Arbitration decision, evaluated combinationally from the current req, with the result registered:
  - mode=0: lowest-index set bit of the candidate set wins.
  - mode=1: first set bit found searching last+1, last+2, … modulo N.
  - On each new grant, last is updated to the winner. This happens in both modes.
- IDLE:
  - If req≠0, go to BUSY with winner=decision(req) and hold=1.
  - Otherwise stay in IDLE.
- BUSY, owner o:
  - **Release.** req[o]=0 means a release; the owner is not re-granted on that decision.
    - If any other req is set, hand over directly to decision(req) with hold=1, staying in BUSY. There is no idle bubble.
    - If no req is set, go to IDLE.
  - **Hold limit.** Applies when req[o]=1, MAX_HOLD≠0, hold==MAX_HOLD, and (req & ~(1<<o))≠0.
    - Forced hand-over to decision(req & ~(1<<o)), with hold=1.
  - **Otherwise** keep owner o.
    - hold increments, saturating at MAX_HOLD. When MAX_HOLD=0 it saturates at 1.
- Non-preemptive: a higher-priority request never displaces the owner before release or the hold limit.
- mode is sampled only at a decision point. Changing mode mid-grant has no effect on the current owner.
- Bits of req at index ≥ N do not exist. Requests that rise and fall between decisions may be missed; requesters must hold req until granted.
- grant_valid equals |grant. grant_id is the binary encoding of grant.

## Timing
- Latency from req rising (sampled at edge k) to grant: grant is high after edge k, i.e. 1 cycle.
- Release: req[o] low at edge k means grant[o] is low after edge k. Any new grant appears in that same cycle.
- Hold limit: the owner holds exactly MAX_HOLD cycles while contended. The new grant appears in the cycle immediately following those MAX_HOLD cycles.
- Reset mid-grant: outputs are zero after the reset edge. The first decision after resetn rises uses last=N-1.
- No combinational path from req or mode to any output.

## Test plan
- **Reset.** Hold resetn=0 for 2 cycles with req=4'b1111 → grant=0, grant_valid=0, grant_id=0. Release reset → grant=4'b0001 one cycle later.
- **Fixed priority.** mode=0, N=4, req=4'b1100 → grant=4'b0100. Next assert req[0] with req[2] held → grant stays 4'b0100. Drop req[2] → grant=4'b0001 the next cycle, no bubble.
- **Round-robin.** mode=1, req=4'b1111 held, each owner drops its req for one cycle after being granted → grant sequence 0001, 0010, 0100, 1000, 0001.
- **Hold limit.** MAX_HOLD=4, mode=1, req=4'b0011 constant → grant[0] for 4 cycles, grant[1] for 4 cycles, then alternation. With req=4'b0001 alone → grant[0] held indefinitely.
- **Mode switch mid-grant.** Owner 2, mode 1→0 while req=4'b0111 → owner 2 kept until release. At release, grant goes to index 0.
- **Reset mid-operation.** resetn=0 while grant=4'b1000 → grant=0 the next cycle. After reset, mode=1 with req=4'b1010 → grant=4'b0010.
